// File: rtl/router_pkt_tx_if.sv
// Signal bundle between the packet transmitter, its upstream byte source and the router input port.
interface router_pkt_tx_if;
   logic       start;
   logic [1:0] addr;
   logic [5:0] payload_len;
   logic [7:0] pl_data;
   logic       pl_valid;
   logic       pl_ready;
   logic       busy;
   logic [7:0] data_out;
   logic       pkt_valid;
   logic       tx_active;
   logic       tx_done;
   logic       err_len;

   // master: the transmitter itself
   modport master (
      input  start, addr, payload_len, pl_data, pl_valid, busy,
      output pl_ready, data_out, pkt_valid, tx_active, tx_done, err_len
   );

   // slave: the environment (request source, payload source and router)
   modport slave (
      output start, addr, payload_len, pl_data, pl_valid, busy,
      input  pl_ready, data_out, pkt_valid, tx_active, tx_done, err_len
   );
endinterface

// File: rtl/router_pkt_tx.sv
// Router packet source: buffers a payload from a valid/ready byte stream, then sends
// header, payload and parity to the router, stalling whenever the router reports busy.
module router_pkt_tx #(
   parameter int GAP_CYCLES = 1
) (
   input  logic           clk,
   input  logic           resetn,
   router_pkt_tx_if.master bus
);
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOAD    = 3'd1;
   localparam logic [2:0] S_HEADER  = 3'd2;
   localparam logic [2:0] S_PAYLOAD = 3'd3;
   localparam logic [2:0] S_PARITY  = 3'd4;
   localparam logic [2:0] S_GAP     = 3'd5;
   localparam logic [3:0] GAP_INIT  = 4'(GAP_CYCLES - 1);

   logic [2:0] state_q, state_d;
   logic [5:0] len_q, len_d;
   logic [1:0] addr_q, addr_d;
   logic [7:0] parity_q, parity_d;
   logic [5:0] wr_cnt_q, wr_cnt_d;
   logic [5:0] rd_idx_q, rd_idx_d;
   logic [3:0] gap_q, gap_d;
   logic [7:0] data_out_q, data_out_d;
   logic       pkt_valid_q, pkt_valid_d;
   logic       tx_active_q, tx_active_d;
   logic       tx_done_q, tx_done_d;
   logic       err_len_q, err_len_d;
   logic       wr_en;
   logic [7:0] header;
   logic [7:0] buf_mem [64];

   assign header = {len_q, addr_q};

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      addr_d      = addr_q;
      parity_d    = parity_q;
      wr_cnt_d    = wr_cnt_q;
      rd_idx_d    = rd_idx_q;
      gap_d       = gap_q;
      data_out_d  = data_out_q;
      pkt_valid_d = pkt_valid_q;
      tx_active_d = tx_active_q;
      tx_done_d   = 1'b0;
      err_len_d   = 1'b0;
      wr_en       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               if (bus.payload_len != 6'd0) begin
                  len_d    = bus.payload_len;
                  addr_d   = bus.addr;
                  parity_d = {bus.payload_len, bus.addr};
                  wr_cnt_d = 6'd0;
                  state_d  = S_LOAD;
               end else begin
                  err_len_d = 1'b1;
               end
            end
         end
         S_LOAD: begin
            if (bus.pl_valid) begin
               wr_en    = 1'b1;
               parity_d = parity_q ^ bus.pl_data;
               wr_cnt_d = wr_cnt_q + 6'd1;
               // Last byte stored: the header is presented on the very next cycle.
               if (wr_cnt_q == len_q - 6'd1) begin
                  data_out_d  = header;
                  pkt_valid_d = 1'b1;
                  tx_active_d = 1'b1;
                  state_d     = S_HEADER;
               end
            end
         end
         S_HEADER: begin
            if (!bus.busy) begin
               data_out_d = buf_mem[0];
               rd_idx_d   = 6'd1;
               state_d    = S_PAYLOAD;
            end
         end
         S_PAYLOAD: begin
            if (!bus.busy) begin
               if (rd_idx_q != len_q) begin
                  data_out_d = buf_mem[rd_idx_q];
                  rd_idx_d   = rd_idx_q + 6'd1;
               end else begin
                  data_out_d  = parity_q;
                  pkt_valid_d = 1'b0;
                  state_d     = S_PARITY;
               end
            end
         end
         S_PARITY: begin
            if (!bus.busy) begin
               data_out_d  = 8'd0;
               tx_active_d = 1'b0;
               tx_done_d   = 1'b1;
               gap_d       = GAP_INIT;
               state_d     = S_GAP;
            end
         end
         S_GAP: begin
            if (gap_q == 4'd0) begin
               state_d = S_IDLE;
            end else begin
               gap_d = gap_q - 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         len_q       <= 6'd0;
         addr_q      <= 2'd0;
         parity_q    <= 8'd0;
         wr_cnt_q    <= 6'd0;
         rd_idx_q    <= 6'd0;
         gap_q       <= 4'd0;
         data_out_q  <= 8'd0;
         pkt_valid_q <= 1'b0;
         tx_active_q <= 1'b0;
         tx_done_q   <= 1'b0;
         err_len_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         addr_q      <= addr_d;
         parity_q    <= parity_d;
         wr_cnt_q    <= wr_cnt_d;
         rd_idx_q    <= rd_idx_d;
         gap_q       <= gap_d;
         data_out_q  <= data_out_d;
         pkt_valid_q <= pkt_valid_d;
         tx_active_q <= tx_active_d;
         tx_done_q   <= tx_done_d;
         err_len_q   <= err_len_d;
      end
   end

   // Payload storage needs no reset; it is always written before it is read.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         buf_mem[wr_cnt_q] <= bus.pl_data;
      end
   end

   assign bus.pl_ready  = (state_q == S_LOAD);
   assign bus.data_out  = data_out_q;
   assign bus.pkt_valid = pkt_valid_q;
   assign bus.tx_active = tx_active_q;
   assign bus.tx_done   = tx_done_q;
   assign bus.err_len   = err_len_q;
endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed-plus-random bench for router_pkt_tx: each packet is predicted from its request and
// payload, then compared byte-for-byte with what a randomly stalling router would consume.
module tb_router_pkt_tx;
   logic clk;
   logic resetn;
   int   vectors;
   int   miscompares;
   logic [7:0] last_b;

   router_pkt_tx_if bus ();

   router_pkt_tx #(.GAP_CYCLES(1)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Sends one request and plays both the payload source and the router.
   task automatic run_pkt(input logic [1:0] a, input logic [5:0] l, input int base,
                          input int vpct, input int bpct, input int wait_exp,
                          input int abort_at, input bit poke, output logic [7:0] last);
      logic [7:0] pay [64];
      logic [7:0] exp_b [$];
      logic       exp_v [$];
      logic [7:0] got_b [$];
      logic       got_v [$];
      int         got_c [$];
      logic [7:0] par;
      int         n, idx, cycles;
      bit         done;
      last = 8'd0;
      for (int i = 0; i < 64; i++)
         pay[i] = (base < 0) ? 8'($urandom) : 8'(base + i);
      par = {l, a};
      exp_b.push_back(par); exp_v.push_back(1'b1);
      for (int i = 0; i < int'(l); i++) begin
         exp_b.push_back(pay[i]); exp_v.push_back(1'b1);
         par = par ^ pay[i];
      end
      exp_b.push_back(par); exp_v.push_back(1'b0);

      bus.start = 1'b1; bus.addr = a; bus.payload_len = l;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.pl_ready && n < 50);
      bus.start = 1'b0;
      chk("load entered", bus.pl_ready, 1);
      if (wait_exp > 0) chk("start to load cycles", n, wait_exp);

      idx = 0; cycles = 0; done = 0;
      while (!done && cycles < 3000) begin
         if (bus.tx_done) begin
            done = 1;
         end else begin
            bus.pl_valid = (bus.pl_ready && idx < int'(l)) ? ($urandom_range(99) < vpct) : 1'b0;
            bus.pl_data  = pay[idx];
            bus.busy     = ($urandom_range(99) < bpct);
            bus.start    = poke && bus.pkt_valid;
            if (poke) begin
               bus.addr = 2'($urandom); bus.payload_len = 6'($urandom);
            end
            if (bus.tx_active && !bus.busy) begin
               got_b.push_back(bus.data_out); got_v.push_back(bus.pkt_valid); got_c.push_back(cycles);
            end
            if (bus.pl_ready && bus.pl_valid) idx++;
            if (abort_at > 0 && got_b.size() == abort_at) begin
               #2 resetn = 1'b0;
               #1;
               chk("reset pkt_valid", bus.pkt_valid, 0);
               chk("reset data_out", bus.data_out, 0);
               chk("reset tx_active", bus.tx_active, 0);
               @(negedge clk);
               bus.start = 0; bus.pl_valid = 0; bus.busy = 0;
               resetn = 1'b1;
               return;
            end
            @(negedge clk);
            cycles++;
         end
      end
      bus.start = 1'b0; bus.pl_valid = 1'b0; bus.busy = 1'b0;
      chk("tx_done seen", done, 1);
      chk("tx_active after done", bus.tx_active, 0);
      chk("packet length", got_b.size(), exp_b.size());
      for (int i = 0; i < got_b.size() && i < exp_b.size(); i++) begin
         chk($sformatf("byte %0d", i), got_b[i], exp_b[i]);
         chk($sformatf("pkt_valid %0d", i), got_v[i], exp_v[i]);
      end
      if (vpct >= 100 && bpct == 0 && got_c.size() > 0) begin
         chk("header latency", got_c[0], l);
         chk("contiguous", got_c[got_c.size()-1] - got_c[0], int'(l) + 1);
      end
      if (got_b.size() > 0) last = got_b[got_b.size()-1];
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      resetn = 1'b0;
      bus.start = 0; bus.addr = 0; bus.payload_len = 0;
      bus.pl_data = 0; bus.pl_valid = 0; bus.busy = 0;
      repeat (3) @(negedge clk);
      chk("rst data_out", bus.data_out, 0);
      chk("rst pkt_valid", bus.pkt_valid, 0);
      chk("rst pl_ready", bus.pl_ready, 0);
      chk("rst tx_active", bus.tx_active, 0);
      chk("rst tx_done", bus.tx_done, 0);
      chk("rst err_len", bus.err_len, 0);
      resetn = 1'b1;
      @(negedge clk);

      // Nominal packet and its single tx_done pulse.
      run_pkt(2'b01, 6'd8, 8'h11, 100, 0, 1, 0, 0, last_b);
      chk("nominal parity", last_b, 8'h29);
      @(negedge clk);
      chk("tx_done one cycle", bus.tx_done, 0);
      chk("tx_active low", bus.tx_active, 0);

      // Router back-pressure at random bytes.
      run_pkt(2'b01, 6'd8, 8'h11, 100, 40, 1, 0, 0, last_b);
      chk("backpressure parity", last_b, 8'h29);
      @(negedge clk);

      run_pkt(2'b10, 6'd1, 8'hA5, 100, 0, 1, 0, 0, last_b);
      chk("len1 parity", last_b, 8'hA3);
      @(negedge clk);
      run_pkt(2'b00, 6'd63, 0, 100, 0, 1, 0, 0, last_b);
      chk("len63 parity", last_b, 8'hC3);
      @(negedge clk);
      run_pkt(2'b11, 6'd63, -1, 40, 30, 1, 0, 0, last_b);
      @(negedge clk);

      // Zero length request.
      bus.start = 1'b1; bus.addr = 2'b01; bus.payload_len = 6'd0;
      @(negedge clk);
      bus.start = 1'b0;
      chk("err_len pulse", bus.err_len, 1);
      chk("zero len pl_ready", bus.pl_ready, 0);
      @(negedge clk);
      chk("err_len clears", bus.err_len, 0);
      chk("zero len stays idle", bus.pl_ready, 0);
      chk("zero len no packet", bus.tx_active, 0);

      // Starts during the packet are ignored; upstream gaps do not change the packet.
      run_pkt(2'b10, 6'd12, -1, 100, 30, 1, 0, 1, last_b);
      @(negedge clk);
      run_pkt(2'b01, 6'd8, 8'h11, 50, 0, 1, 0, 0, last_b);
      chk("stalled parity", last_b, 8'h29);
      @(negedge clk);

      // Reset in the middle of the payload, then a clean packet.
      run_pkt(2'b01, 6'd20, -1, 100, 20, 1, 4, 0, last_b);
      run_pkt(2'b11, 6'd5, -1, 100, 0, 1, 0, 0, last_b);

      // Back-to-back requests: exactly GAP_CYCLES+1 cycles from tx_done to LOAD.
      for (int k = 0; k < 6; k++)
         run_pkt(2'($urandom), 6'($urandom_range(63, 1)), -1,
                 $urandom_range(100, 40), $urandom_range(50, 0), 2, 0, k[0], last_b);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
